dacs_spi_multi: RTL and testbench

Parametrised multi-channel serial DAC driver, successor to the fixed 4-channel AD5541A driver. It accepts one word per channel through a valid/ready handshake and converts signed samples to offset binary. It shifts all selected channels out in parallel on a shared SCLK with per-channel CS_N/SDO lines, and optionally issues a common LDAC pulse for simultaneous update. It sits in the ADC_outclock_50 domain between the controller/NCO outputs and the DAC pins.

---
 rtl/dacs_spi_pkg.sv | 32 +++
 rtl/dacs_spi_tick.sv | 37 +++
 rtl/dacs_spi_multi.sv | 135 +++++++++++++
 tb/tb_dacs_spi_multi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dacs_spi_pkg.sv
// Shared types and helpers for the dacs_spi_multi DAC driver.
// The LDAC state exists only when DACS_SPI_LDAC_EN is defined.
package dacs_spi_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
`ifdef DACS_SPI_LDAC_EN
    , S_LDAC = 2'd3
`endif
  } dacs_state_e;

  // Cycles from one capture to the earliest next capture (frame_done cycle).
  function automatic int frame_len(input int data_w, input int clk_div,
                                   input int cs_gap, input bit ldac_en);
    return 2 * data_w * clk_div + cs_gap + 1 + (ldac_en ? clk_div : 0);
  endfunction

  // Two's complement to offset binary is just an MSB flip; words up to MAX_W bits.
  function automatic logic [MAX_W-1:0] to_offset(input logic [MAX_W-1:0] word,
                                                 input int width,
                                                 input bit signed_in);
    logic [MAX_W-1:0] msb;
    msb = '0;
    if (signed_in) msb[width-1] = 1'b1;
    return word ^ msb;
  endfunction

endpackage

// File: rtl/dacs_spi_tick.sv
// SCLK divider: half-period tick plus the registered sclk phase.
// Restarts cleanly on every frame start so the first low half is always full length.
module dacs_spi_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic run,
  output logic tick,
  output logic phase
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (run) begin
      if (tick) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dacs_spi_multi.sv
// Multi-channel serial DAC driver: per-channel CS_N/SDO shifted in parallel on a shared SCLK.
// Define DACS_SPI_LDAC_EN to add a common LDAC pulse after each frame; otherwise ldac_n is tied low.
module dacs_spi_multi
  import dacs_spi_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 2,
  parameter int SIGNED_IN = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   sclk,
  output logic [N_CH-1:0]        cs_n,
  output logic [N_CH-1:0]        sdo,
  output logic                   ldac_n
);

`ifdef DACS_SPI_LDAC_EN
  localparam bit LDAC_EN = 1'b1;
`else
  localparam bit LDAC_EN = 1'b0;
`endif
  localparam int FRAME_LEN = frame_len(DATA_W, CLK_DIV, CS_GAP, LDAC_EN);
  localparam int LAST_CYC  = FRAME_LEN - 2;
  localparam int GAP_END   = LAST_CYC - (LDAC_EN ? CLK_DIV : 0);
  localparam int BW        = $clog2(DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  dacs_state_e      state, next_state;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic             capture, any_mask, tick, last_bit;

  assign data_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign capture    = data_valid && (state == S_IDLE);
  assign any_mask   = |ch_mask;
  assign last_bit   = tick && sclk && (bit_cnt == BW'(DATA_W - 1));

  dacs_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (capture),
    .run     (state == S_SHIFT),
    .tick    (tick),
    .phase   (sclk)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // frame_cnt is zero in the first busy cycle, so GAP and LDAC end on fixed counts.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (capture && any_mask) next_state = S_SHIFT;
      S_SHIFT: if (last_bit) next_state = S_GAP;
      S_GAP: begin
        if (frame_cnt == CNT_W'(GAP_END)) begin
`ifdef DACS_SPI_LDAC_EN
          next_state = S_LDAC;
`else
          next_state = S_IDLE;
`endif
        end
      end
`ifdef DACS_SPI_LDAC_EN
      S_LDAC:  if (frame_cnt == CNT_W'(LAST_CYC)) next_state = S_IDLE;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      frame_cnt  <= '0;
      cs_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (capture && !any_mask) ||
                    ((state != S_IDLE) && (next_state == S_IDLE));

      if (capture)              frame_cnt <= '0;
      else if (state != S_IDLE) frame_cnt <= frame_cnt + 1'b1;

      if (capture || last_bit)    bit_cnt <= '0;
      else if (tick && sclk)      bit_cnt <= bit_cnt + 1'b1;

      if (capture && any_mask) cs_n <= ~ch_mask;
      else if (last_bit)       cs_n <= '1;
    end
  end

  // Unmasked channels load zero, so their sdo stays low for the whole frame.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shreg <= '0;
      end else if (capture) begin
        shreg <= ch_mask[i]
               ? DATA_W'(to_offset(MAX_W'(data_in[i*DATA_W +: DATA_W]), DATA_W, SIGNED_IN != 0))
               : '0;
      end else if (last_bit) begin
        shreg <= '0;
      end else if (tick && sclk) begin
        shreg <= {shreg[DATA_W-2:0], 1'b0};
      end
    end

    assign sdo[i] = shreg[DATA_W-1];
  end

`ifdef DACS_SPI_LDAC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ldac_n <= 1'b1;
    else          ldac_n <= (next_state != S_LDAC);
  end
`else
  assign ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dacs_spi_multi.sv
// Randomised bench for dacs_spi_multi against a cycle-offset waveform model.
// With DACS_SPI_LDAC_EN defined the bench runs CLK_DIV=1 and expects the LDAC pulse.
module tb_dacs_spi_multi;

  localparam int N_CH   = 4;
  localparam int DATA_W = 16;
  localparam int CS_GAP = 2;
`ifdef DACS_SPI_LDAC_EN
  localparam int CLK_DIV = 1;
  localparam bit LDAC_EN = 1'b1;
`else
  localparam int CLK_DIV = 2;
  localparam bit LDAC_EN = 1'b0;
`endif
  localparam int SH = 2 * DATA_W * CLK_DIV;
  localparam int FL = SH + CS_GAP + 1 + (LDAC_EN ? CLK_DIV : 0);

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N_CH*DATA_W-1:0] data_in;
  logic [N_CH-1:0]        ch_mask;
  logic                   data_valid;
  logic                   data_ready, busy, frame_done, sclk, ldac_n;
  logic [N_CH-1:0]        cs_n, sdo;

  int                n_checks = 0;
  int                n_pass   = 0;
  int                cyc      = 0;
  bit                have_frame = 1'b0;
  int                t0 = 0;
  logic [N_CH-1:0]   f_mask;
  logic [DATA_W-1:0] f_word [N_CH];
  logic [DATA_W-1:0] rx [N_CH];
  int                rises = 0;
  logic              prev_sclk = 1'b0;
  bit                captured = 1'b0;

  dacs_spi_multi #(
    .N_CH(N_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .SIGNED_IN(1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .ch_mask    (ch_mask),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .sdo        (sdo),
    .ldac_n     (ldac_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Signed sample plus half scale gives the offset-binary code.
  function automatic int offset_of(input logic [DATA_W-1:0] w);
    int v;
    v = int'(w);
    if (v >= (1 << (DATA_W - 1))) v = v - (1 << DATA_W);
    return v + (1 << (DATA_W - 1));
  endfunction

  // Expected {sclk, cs_n, sdo, ldac_n, frame_done, busy, data_ready} in cycle c.
  function automatic logic [12:0] model_out(input int c);
    int n, k, ph;
    logic s, ld, fd, bz;
    logic [N_CH-1:0] cs, sd;
    logic [DATA_W-1:0] ow;
    s = 1'b0; cs = '1; sd = '0; ld = LDAC_EN; fd = 1'b0; bz = 1'b0;
    if (have_frame) begin
      n = c - t0;
      if (f_mask == '0) begin
        fd = (n == 1);
      end else begin
        bz = (n >= 1) && (n < FL);
        fd = (n == FL);
        if (n >= 1 && n <= SH) begin
          k  = (n - 1) / (2 * CLK_DIV);
          ph = (n - 1) % (2 * CLK_DIV);
          s  = (ph >= CLK_DIV);
          for (int i = 0; i < N_CH; i++) begin
            ow    = DATA_W'(offset_of(f_word[i]));
            cs[i] = !f_mask[i];
            sd[i] = f_mask[i] && ow[DATA_W-1-k];
          end
        end
        if (LDAC_EN && n > SH + CS_GAP && n <= SH + CS_GAP + CLK_DIV) ld = 1'b0;
      end
    end
    return {s, cs, sd, ld, fd, bz, !bz};
  endfunction

  function automatic logic [N_CH*DATA_W-1:0] rand_data();
    logic [N_CH*DATA_W-1:0] d;
    for (int i = 0; i < N_CH; i++) d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return d;
  endfunction

  task automatic applyStimulus(input logic valid, input logic [N_CH-1:0] mask,
                               input logic [N_CH*DATA_W-1:0] data);
    data_valid = valid;
    ch_mask    = mask;
    data_in    = data;
  endtask

  // One clock: check outputs mid-cycle, collect SDO on SCLK rises, log any capture.
  task automatic runCycle();
    logic [12:0] exp_v;
    @(negedge clk);
    exp_v = model_out(cyc);
    checkOutput($sformatf("outputs@cyc%0d", cyc),
                32'({sclk, cs_n, sdo, ldac_n, frame_done, busy, data_ready}), 32'(exp_v));
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      rises++;
      for (int i = 0; i < N_CH; i++) rx[i] = {rx[i][DATA_W-2:0], sdo[i]};
    end
    prev_sclk = sclk;
    if (have_frame && exp_v[2]) begin
      for (int i = 0; i < N_CH; i++)
        checkOutput($sformatf("word_ch%0d", i), 32'(rx[i]),
                    f_mask[i] ? 32'(offset_of(f_word[i])) : 32'd0);
      checkOutput("sclk_rises", rises, (f_mask != '0) ? DATA_W : 0);
    end
    captured = 1'b0;
    if (reset_n && data_valid && exp_v[0]) begin
      have_frame = 1'b1;
      t0         = cyc;
      f_mask     = ch_mask;
      for (int i = 0; i < N_CH; i++) begin
        f_word[i] = data_in[i*DATA_W +: DATA_W];
        rx[i]     = '0;
      end
      rises    = 0;
      captured = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitCapture();
    int guard = 0;
    do begin
      runCycle();
      guard++;
    end while (!captured && guard < FL + 4);
    if (!captured) begin
      n_checks++;
      $display("[TB] FAIL capture_timeout: got no capture, expected one within %0d cycles", FL + 4);
    end
  endtask

  task automatic sendFrame(input logic [N_CH-1:0] mask, input logic [N_CH*DATA_W-1:0] data);
    applyStimulus(1'b1, mask, data);
    waitCapture();
    applyStimulus(1'b0, mask, data);
  endtask

  task automatic waitIdle(input int extra);
    logic [12:0] m;
    for (int g = 0; g < FL + 2; g++) begin
      m = model_out(cyc);
      if (m[0]) break;
      runCycle();
    end
    for (int j = 0; j < extra; j++) runCycle();
  endtask

  task automatic resetCheck(input string tag);
    checkOutput(tag, 32'({sclk, cs_n, sdo, busy, data_ready, frame_done, ldac_n}),
                32'({1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, LDAC_EN}));
  endtask

  initial begin
    reset_n = 1'b1;
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < N_CH; i++) rx[i] = '0;
    #1 reset_n = 1'b0;
    #1 resetCheck("reset_async");
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) runCycle();
    reset_n = 1'b1;
    runCycle();
    runCycle();

    $display("[TB] full frame, known words");
    sendFrame(4'hF, {16'h1234, 16'h8000, 16'h7FFF, 16'h0000});
    waitIdle(3);

    $display("[TB] partial mask 0101");
    sendFrame(4'b0101, rand_data());
    waitIdle(2);

    $display("[TB] empty mask");
    sendFrame(4'h0, rand_data());
    waitIdle(3);

    $display("[TB] reset mid-frame");
    sendFrame(4'hF, rand_data());
    while (cyc < t0 + 30) runCycle();
    reset_n = 1'b0;
    #1 resetCheck("reset_midframe");
    have_frame = 1'b0;
    runCycle();
    runCycle();
    reset_n = 1'b1;
    runCycle();
    sendFrame(4'hF, rand_data());
    waitIdle(2);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 4'(($urandom_range(1, 15))), rand_data());
    for (int f = 0; f < 3; f++) begin
      waitCapture();
      applyStimulus(1'b1, 4'(($urandom_range(1, 15))), rand_data());
    end
    applyStimulus(1'b0, '0, '0);
    waitIdle(2);

    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      sendFrame(4'(($urandom_range(0, 15))), rand_data());
      for (int j = 0; j < int'($urandom_range(0, FL + 5)); j++) runCycle();
    end
    waitIdle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
